int_div_seq_unit: RTL and testbench
===================================

INT_DIV_SEQ_UNIT -- requirements
Module: int_div_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal range 8..64).
REQ-002 Parameter TAG_WIDTH, default 2, width of the tag carried alongside each operation.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 En_i  input  1  request valid; the operation is accepted when En_i and Ready_o are both 1.
REQ-006 Ready_o  output  1  unit can accept a request in the current cycle.
REQ-007 OpA_i  input  WIDTH  dividend.
REQ-008 OpB_i  input  WIDTH  divisor.
REQ-009 Op_i  input  2  operation select: 00 DIVU, 01 DIV (signed), 10 REMU, 11 REM (signed).
REQ-010 Tag_i  input  TAG_WIDTH  request tag.
REQ-011 Res_o  output  WIDTH  result (quotient or remainder).
REQ-012 Tag_o  output  TAG_WIDTH  tag of the operation currently presented on Res_o.
REQ-013 Valid_o  output  1  Res_o and Tag_o are valid.
REQ-014 Ack_i  input  1  consumer accepts the result; the result is consumed when Valid_o and Ack_i are both 1.
REQ-015 Status_o  output  2  exists only with the INT_DIV_STATUS_EN macro; bit0 is divide-by-zero, bit1 is signed overflow.

Function
REQ-016 The unit SHALL implement a 3-state FSM with states IDLE, BUSY and DONE.
REQ-017 Ready_o SHALL be 1 in IDLE, 0 in BUSY, and equal to Ack_i in DONE.
REQ-018 On acceptance, the unit SHALL register the operands, Op_i and Tag_i, and ignore input changes until the next acceptance.
REQ-019 From IDLE, a normal acceptance SHALL move the FSM to BUSY and load the iteration counter with WIDTH-1.
REQ-020 In BUSY, the unit SHALL perform one restoring radix-2 step per cycle on operand magnitudes, using a WIDTH+1-bit partial remainder.
REQ-021 When the counter reaches 0 in BUSY, the FSM SHALL move to DONE after that step; Valid_o SHALL rise exactly WIDTH+1 cycles after the acceptance edge.
REQ-022 The sign fix-up SHALL be applied on entry to DONE: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
REQ-023 A zero divisor SHALL bypass BUSY and go directly to DONE, with Valid_o rising 1 cycle after acceptance.
  - Quotient result: all ones.
  - Remainder result: the dividend.
REQ-024 Signed overflow (OpA_i equal to the most negative value, OpB_i equal to all ones, signed op) SHALL likewise bypass BUSY.
  - DIV result: the most negative value.
  - REM result: 0.
REQ-025 In DONE, Res_o, Tag_o and Valid_o SHALL hold stable until Ack_i is 1.
REQ-026 On Ack_i without En_i, the FSM SHALL return to IDLE and Valid_o SHALL drop on the next cycle.
REQ-027 On Ack_i and En_i in the same DONE cycle, the unit SHALL accept the new request (back-to-back operation).
  - Next state: BUSY, or DONE for a bypass case.
  - No idle bubble is inserted.
REQ-028 En_i in BUSY SHALL be ignored, with no state change and no loss of the operation in flight.
REQ-029 Ack_i while Valid_o is 0 SHALL have no effect.

Reset
REQ-030 While rst_ni is 0, the unit SHALL hold the following values regardless of clk_i:
  - FSM in IDLE, counter 0.
  - Res_o 0, Tag_o 0, Valid_o 0, Ready_o 1.
  - Status_o 0 when present.
REQ-031 Reset asserted in BUSY or DONE SHALL discard the operation in flight; after release, no Valid_o pulse for it SHALL appear.
REQ-032 The first acceptance SHALL be possible in the first cycle after rst_ni rises.

Configuration
REQ-033 With the macro INT_DIV_STATUS_EN defined, the Status_o port SHALL exist.
  - Status_o is registered with the result and is valid while Valid_o is 1.
  - Bit0 is set for the zero-divisor case; bit1 is set for signed overflow.
REQ-034 Without INT_DIV_STATUS_EN, the Status_o port and its registers SHALL be absent; all other behaviour is identical.

Verification
REQ-035 WIDTH=32, DIVU 100/7, Tag 2, Ack_i held 1 -> Valid_o rises at cycle 33 after acceptance, Res_o=14, Tag_o=2, Valid_o high for 1 cycle.
REQ-036 REM -7 (0xFFFFFFF9) by 2 -> Res_o=0xFFFFFFFF; DIV with the same operands -> Res_o=0xFFFFFFFD.
REQ-037 DIVU 5/0 -> Valid_o 1 cycle after acceptance, Res_o=0xFFFFFFFF, Status_o=01; REMU 5/0 -> Res_o=5.
REQ-038 DIV 0x80000000 by 0xFFFFFFFF -> Res_o=0x80000000, Status_o=10, bypass latency 1 cycle.
REQ-039 Ack_i held 0 for 10 cycles in DONE with En_i held 1 -> Res_o stable and Ready_o 0; then Ack_i=1 with En_i=1 -> the new op is accepted in that same cycle and BUSY is entered next.
REQ-040 rst_ni pulsed low at cycle 10 of BUSY -> Valid_o stays 0 and Ready_o=1 after release; the next op 9/3 returns 3.

Source files
------------

// File: rtl/int_div_seq_unit.sv
// Sequential radix-2 restoring integer divider (DIVU/DIV/REMU/REM).
// Optional Status_o port under macro INT_DIV_STATUS_EN.
module int_div_seq_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 En_i,
  output logic                 Ready_o,
  input  logic [WIDTH-1:0]     OpA_i,
  input  logic [WIDTH-1:0]     OpB_i,
  input  logic [1:0]           Op_i,
  input  logic [TAG_WIDTH-1:0] Tag_i,
  output logic [WIDTH-1:0]     Res_o,
  output logic [TAG_WIDTH-1:0] Tag_o,
  output logic                 Valid_o,
  input  logic                 Ack_i
`ifdef INT_DIV_STATUS_EN
  ,
  output logic [1:0]           Status_o
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     res_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TAG_WIDTH-1:0] tago_q;
  logic                 valid_q;
  logic                 qneg_q;
  logic                 rneg_q;
  logic                 isrem_q;
`ifdef INT_DIV_STATUS_EN
  logic [1:0]           st_q;
`endif

  logic                 accept;
  logic                 sgn;
  logic                 sa;
  logic                 sb;
  logic [WIDTH-1:0]     maga;
  logic [WIDTH-1:0]     magb;
  logic                 zero;
  logic                 ovf;
  logic                 byp;
  logic [WIDTH-1:0]     byp_res;

  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic                 fit;
  logic [WIDTH-1:0]     rem_nx;
  logic [WIDTH-1:0]     quo_nx;
  logic [WIDTH-1:0]     qfix;
  logic [WIDTH-1:0]     rfix;
  logic [WIDTH-1:0]     fin;

  always_comb begin
    Ready_o = 1'b0;
    unique case (state_q)
      IDLE:    Ready_o = 1'b1;
      BUSY:    Ready_o = 1'b0;
      DONE:    Ready_o = Ack_i;
      default: Ready_o = 1'b0;
    endcase
  end

  assign accept = En_i & Ready_o;

  // Request decode: magnitudes, sign flags and the bypass cases.
  always_comb begin
    sgn  = Op_i[0];
    sa   = sgn & OpA_i[WIDTH-1];
    sb   = sgn & OpB_i[WIDTH-1];
    maga = sa ? ('0 - OpA_i) : OpA_i;
    magb = sb ? ('0 - OpB_i) : OpB_i;
    zero = (OpB_i == '0);
    ovf  = sgn & (OpA_i == MIN_NEG) & (&OpB_i);
    byp  = zero | ovf;
    if (zero) begin
      byp_res = Op_i[1] ? OpA_i : '1;
    end else begin
      byp_res = Op_i[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    fit    = ~diff[WIDTH];
    rem_nx = fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], fit};
    qfix   = qneg_q ? ('0 - quo_nx) : quo_nx;
    rfix   = rneg_q ? ('0 - rem_nx) : rem_nx;
    fin    = isrem_q ? rfix : qfix;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      tago_q  <= '0;
      valid_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
`ifdef INT_DIV_STATUS_EN
      st_q    <= '0;
`endif
    end else if (accept) begin
      tag_q   <= Tag_i;
      isrem_q <= Op_i[1];
      qneg_q  <= sa ^ sb;
      rneg_q  <= sa;
      rem_q   <= '0;
      quo_q   <= maga;
      div_q   <= magb;
      if (byp) begin
        state_q <= DONE;
        cnt_q   <= '0;
        res_q   <= byp_res;
        tago_q  <= Tag_i;
        valid_q <= 1'b1;
`ifdef INT_DIV_STATUS_EN
        st_q    <= {ovf, zero};
`endif
      end else begin
        state_q <= BUSY;
        cnt_q   <= CW'(WIDTH-1);
        valid_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q == '0) begin
            state_q <= DONE;
            res_q   <= fin;
            tago_q  <= tag_q;
            valid_q <= 1'b1;
`ifdef INT_DIV_STATUS_EN
            st_q    <= '0;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (Ack_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Res_o   = res_q;
  assign Tag_o   = tago_q;
  assign Valid_o = valid_q;
`ifdef INT_DIV_STATUS_EN
  assign Status_o = st_q;
`endif

endmodule

// File: tb/tb_int_div_seq_unit.sv
// Bench for int_div_seq_unit: arithmetic model + cycle scoreboard.
// Checks Status_o only when INT_DIV_STATUS_EN is defined.
module tb_int_div_seq_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        En_i = 1'b0;
  logic        Ready_o;
  logic [31:0] OpA_i = '0;
  logic [31:0] OpB_i = '0;
  logic [1:0]  Op_i = '0;
  logic [1:0]  Tag_i = '0;
  logic [31:0] Res_o;
  logic [1:0]  Tag_o;
  logic        Valid_o;
  logic        Ack_i = 1'b1;
`ifdef INT_DIV_STATUS_EN
  logic [1:0]  Status_o;
`endif

  int_div_seq_unit #(.WIDTH(32), .TAG_WIDTH(2)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .En_i    (En_i),
    .Ready_o (Ready_o),
    .OpA_i   (OpA_i),
    .OpB_i   (OpB_i),
    .Op_i    (Op_i),
    .Tag_i   (Tag_i),
    .Res_o   (Res_o),
    .Tag_o   (Tag_o),
    .Valid_o (Valid_o),
    .Ack_i   (Ack_i)
`ifdef INT_DIV_STATUS_EN
    ,
    .Status_o(Status_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  tag;
    logic [1:0]  st;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res = '0;
  logic [1:0]  last_tag = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic is_ovf(input logic [1:0] op,
                                  input logic [31:0] a, b);
    return op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Division semantics from plain arithmetic on 64-bit signed values.
  function automatic logic [31:0] mdl_res(input logic [1:0] op,
                                          input logic [31:0] a, b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (is_ovf(op, a, b)) return op[1] ? 32'h0 : a;
    case (op)
      2'd0:    r = longint'(a / b);
      2'd1:    r = sa / sb;
      2'd2:    r = longint'(a % b);
      default: r = sa % sb;
    endcase
    return r[31:0];
  endfunction

  function automatic int mdl_lat(input logic [1:0] op,
                                 input logic [31:0] a, b);
    return (b == 0 || is_ovf(op, a, b)) ? 1 : 33;
  endfunction

  function automatic logic [1:0] mdl_st(input logic [1:0] op,
                                        input logic [31:0] a, b);
    return {b != 0 && is_ovf(op, a, b), b == 0};
  endfunction

  // Per-cycle compare against the scoreboard.
  always @(negedge clk_i) begin
    logic shown;
    if (!rst_ni) begin
      chk("rst_valid", Valid_o, 0);
      chk("rst_ready", Ready_o, 1);
      chk("rst_res", Res_o, 0);
      chk("rst_tag", Tag_o, 0);
      q.delete();
    end else begin
      shown = q.size() > 0 && cyc >= q[0].due;
      if (shown) begin
        chk("valid_hi", Valid_o, 1);
        chk("res", Res_o, q[0].res);
        chk("tag", Tag_o, q[0].tag);
`ifdef INT_DIV_STATUS_EN
        chk("status", Status_o, q[0].st);
`endif
        chk("ready_done", Ready_o, Ack_i);
        if (Ack_i) begin
          last_res = Res_o;
          last_tag = Tag_o;
          void'(q.pop_front());
        end
      end else begin
        chk("valid_lo", Valid_o, 0);
        chk("ready", Ready_o, (q.size() > 0) ? 1'b0 : 1'b1);
      end
      if (En_i && Ready_o) begin
        q.push_back('{res: mdl_res(Op_i, OpA_i, OpB_i),
                      tag: Tag_i,
                      st:  mdl_st(Op_i, OpA_i, OpB_i),
                      due: cyc + mdl_lat(Op_i, OpA_i, OpB_i)});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, b,
                       input logic [1:0] tag);
    En_i  = 1'b1;
    Op_i  = op;
    OpA_i = a;
    OpB_i = b;
    Tag_i = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (Ready_o) begin
        @(posedge clk_i);
        #2;
        En_i = 1'b0;
        return;
      end
    end
    chk("issue_timeout", 1, 0);
    En_i = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      #1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk_i);
    #2;
  endtask

  logic [1:0]  bop[11];
  logic [31:0] ba[11];
  logic [31:0] bb[11];

  initial begin
    bop = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd2,
            2'd1, 2'd3, 2'd3, 2'd0, 2'd1};
    ba  = '{32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100,
            32'd100, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
            32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    bb  = '{32'd1, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'd16, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
            32'd1};

    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;

    chk("pin_divu", mdl_res(2'd0, 32'd100, 32'd7), 32'd14);
    chk("pin_rem", mdl_res(2'd3, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin_div", mdl_res(2'd1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_div2", mdl_res(2'd1, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
    chk("pin_lat", mdl_lat(2'd0, 32'd100, 32'd7), 33);

    issue(2'd0, 32'd100, 32'd7, 2'd2);
    wait_empty(100);
    chk("divu_100_7", last_res, 32'd14);
    chk("divu_tag", last_tag, 2'd2);

    issue(2'd3, 32'hFFFF_FFF9, 32'd2, 2'd1);
    wait_empty(100);
    chk("rem_m7_2", last_res, 32'hFFFF_FFFF);
    issue(2'd1, 32'hFFFF_FFF9, 32'd2, 2'd1);
    wait_empty(100);
    chk("div_m7_2", last_res, 32'hFFFF_FFFD);

    issue(2'd0, 32'd5, 32'd0, 2'd3);
    wait_empty(100);
    chk("divu_5_0", last_res, 32'hFFFF_FFFF);
    issue(2'd2, 32'd5, 32'd0, 2'd0);
    wait_empty(100);
    chk("remu_5_0", last_res, 32'd5);

    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 2'd2);
    wait_empty(100);
    chk("div_ovf", last_res, 32'h8000_0000);

    for (int i = 0; i < 11; i++) begin
      issue(bop[i], ba[i], bb[i], 2'(i));
    end
    wait_empty(600);
    chk("b2b_last", last_res, 32'h8000_0000);

    Ack_i = 1'b0;
    issue(2'd0, 32'd1000, 32'd10, 2'd1);
    En_i  = 1'b1;
    Op_i  = 2'd1;
    OpA_i = 32'hFFFF_FFB3;
    OpB_i = 32'd7;
    Tag_i = 2'd3;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (Valid_o) break;
    end
    repeat (10) @(negedge clk_i);
    #1;
    chk("hold_res", Res_o, 32'd100);
    chk("hold_ready", Ready_o, 0);
    @(posedge clk_i);
    #2;
    Ack_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk("b2b_ready", Ready_o, 1);
    @(posedge clk_i);
    #1;
    chk("b2b_busy_ready", Ready_o, 0);
    chk("b2b_busy_valid", Valid_o, 0);
    #1;
    En_i = 1'b0;
    wait_empty(100);
    chk("div_m77_7", last_res, 32'hFFFF_FFF5);
    chk("div_m77_tag", last_tag, 2'd3);

    issue(2'd0, 32'd100, 32'd7, 2'd2);
    repeat (10) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_valid", Valid_o, 0);
    chk("async_ready", Ready_o, 1);
    chk("async_res", Res_o, 0);
    chk("async_tag", Tag_o, 0);
    En_i  = 1'b1;
    Op_i  = 2'd0;
    OpA_i = 32'd9;
    OpB_i = 32'd3;
    Tag_i = 2'd1;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #2;
    En_i = 1'b0;
    wait_empty(100);
    chk("post_rst_9_3", last_res, 32'd3);
    chk("post_rst_tag", last_tag, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
